radiant_event_header: RTL and testbench

// - Downstream of the trigger governor: snapshots per-trigger bookkeeping on every accepted trigger pulse.
// - Queues snapshots as header entries and streams each one out as a fixed-length 32-bit word packet to the DMA/readout path.
// - Gives software event numbering, PPS-relative timestamps, dead-trigger counts and overflow accounting for every event.

---
 rtl/radiant_event_header.sv | 209 ++++++++++++++++++++
 tb/tb_radiant_event_header.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/radiant_event_header.sv
// Event header builder: snapshots trigger bookkeeping into a FIFO and streams 5-word headers.
// Define HDR_DEADTIME_EN to add the dead-cycle counter as a sixth word.
module radiant_event_header #(
  parameter int         HDR_DEPTH_LOG2 = 4,
  parameter logic [7:0] HDR_MAGIC      = 8'hEB
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic                      trig_i,
  input  logic [15:0]               trig_info_i,
  input  logic                      deadtrig_i,
  input  logic                      dead_i,
  input  logic                      pps_i,
  input  logic                      hdr_tready_i,
  output logic [31:0]               hdr_tdata_o,
  output logic                      hdr_tvalid_o,
  output logic                      hdr_tlast_o,
  output logic                      hdr_full_o,
  output logic [HDR_DEPTH_LOG2:0]   hdr_count_o
);

`ifdef HDR_DEADTIME_EN
  localparam int NWORDS = 6;
`else
  localparam int NWORDS = 5;
`endif
  localparam int DEPTH = 2 ** HDR_DEPTH_LOG2;

  typedef struct packed {
    logic [15:0] info;
    logic [7:0]  drop;
    logic [31:0] evt;
    logic [31:0] pps;
    logic [31:0] cyc;
    logic [15:0] deadtrig;
`ifdef HDR_DEADTIME_EN
    logic [31:0] dead;
`endif
  } entry_t;

  typedef enum logic {IDLE, SEND} state_t;

  logic [31:0] cyc_q, cyc_d, pps_q, pps_d, evt_q;
  logic [15:0] deadtrig_q;
  logic [7:0]  drop_q;

  entry_t                    mem [DEPTH];
  entry_t                    new_entry, cur_q;
  logic [HDR_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [HDR_DEPTH_LOG2:0]   count_q;
  logic                      fifo_empty, fifo_full, accept, pop;

  state_t      state_q, state_d;
  logic [2:0]  w_q, w_d;
  logic        last_word;
  logic [31:0] word;

  // Counter values as they will be after this edge; snapshots use these.
  assign cyc_d = pps_i ? 32'd0 : cyc_q + 32'd1;
  assign pps_d = pps_q + {31'd0, pps_i};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (HDR_DEPTH_LOG2+1)'(DEPTH));
  // A pop in the same cycle frees a slot, so the trigger still fits.
  assign accept     = trig_i && (!fifo_full || pop);

`ifdef HDR_DEADTIME_EN
  logic [31:0] dead_q;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      dead_q <= '0;
    end else if (accept) begin
      dead_q <= {31'd0, dead_i};
    end else if (dead_i && dead_q != 32'hFFFF_FFFF) begin
      dead_q <= dead_q + 32'd1;
    end
  end
`else
  logic unused_dead;
  assign unused_dead = dead_i;
`endif

  always_comb begin
    new_entry          = '0;
    new_entry.info     = trig_info_i;
    new_entry.drop     = drop_q;
    new_entry.evt      = evt_q;
    new_entry.pps      = pps_d;
    new_entry.cyc      = cyc_d;
    new_entry.deadtrig = deadtrig_q;
`ifdef HDR_DEADTIME_EN
    new_entry.dead     = dead_q;
`endif
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      cyc_q      <= '0;
      pps_q      <= '0;
      evt_q      <= '0;
      deadtrig_q <= '0;
      drop_q     <= '0;
    end else begin
      cyc_q <= cyc_d;
      pps_q <= pps_d;
      if (accept) begin
        evt_q      <= evt_q + 32'd1;
        deadtrig_q <= {15'd0, deadtrig_i};
        drop_q     <= '0;
      end else begin
        if (trig_i && drop_q != 8'hFF)
          drop_q <= drop_q + 8'd1;
        if (deadtrig_i && deadtrig_q != 16'hFFFF)
          deadtrig_q <= deadtrig_q + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (accept)
      mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + HDR_DEPTH_LOG2'(1);
      if (pop)
        rd_ptr <= rd_ptr + HDR_DEPTH_LOG2'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + (HDR_DEPTH_LOG2+1)'(1);
        2'b01:   count_q <= count_q - (HDR_DEPTH_LOG2+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign last_word = (w_q == 3'(NWORDS - 1));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
          w_d     = '0;
        end
      end
      SEND: begin
        if (hdr_tready_i) begin
          if (last_word) begin
            w_d = '0;
            // Chain straight into the next header when one is waiting.
            if (!fifo_empty)
              pop = 1'b1;
            else
              state_d = IDLE;
          end else begin
            w_d = w_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      w_q     <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      if (pop)
        cur_q <= mem[rd_ptr];
    end
  end

  always_comb begin
    word = '0;
    case (w_q)
      3'd0:    word = {HDR_MAGIC, cur_q.drop, cur_q.info};
      3'd1:    word = cur_q.evt;
      3'd2:    word = cur_q.pps;
      3'd3:    word = cur_q.cyc;
      3'd4:    word = {16'h0000, cur_q.deadtrig};
`ifdef HDR_DEADTIME_EN
      3'd5:    word = cur_q.dead;
`endif
      default: word = '0;
    endcase
  end

  assign hdr_tvalid_o = (state_q == SEND);
  assign hdr_tdata_o  = hdr_tvalid_o ? word : 32'd0;
  assign hdr_tlast_o  = hdr_tvalid_o && last_word;
  assign hdr_full_o   = fifo_full;
  assign hdr_count_o  = count_q;

endmodule

// File: tb/tb_radiant_event_header.sv
// Bench for radiant_event_header: transaction-level model (queue of header packets) checked every cycle,
// plus directed value checks on the captured output word log.
module tb_radiant_event_header;
  localparam int LOG2  = 4;
  localparam int DEPTH = 16;
`ifdef HDR_DEADTIME_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        sys_clk_i = 1'b0;
  logic        rst_i, trig_i, deadtrig_i, dead_i, pps_i, hdr_tready_i;
  logic [15:0] trig_info_i;
  logic [31:0] hdr_tdata_o;
  logic        hdr_tvalid_o, hdr_tlast_o, hdr_full_o;
  logic [LOG2:0] hdr_count_o;

  radiant_event_header #(.HDR_DEPTH_LOG2(LOG2), .HDR_MAGIC(8'hEB)) dut (
    .sys_clk_i(sys_clk_i), .rst_i(rst_i), .trig_i(trig_i), .trig_info_i(trig_info_i),
    .deadtrig_i(deadtrig_i), .dead_i(dead_i), .pps_i(pps_i), .hdr_tready_i(hdr_tready_i),
    .hdr_tdata_o(hdr_tdata_o), .hdr_tvalid_o(hdr_tvalid_o), .hdr_tlast_o(hdr_tlast_o),
    .hdr_full_o(hdr_full_o), .hdr_count_o(hdr_count_o));

  always #5 sys_clk_i = ~sys_clk_i;

  typedef logic [5:0][31:0] pkt_t;
  pkt_t        m_fifo[$];
  pkt_t        m_cur;
  bit          m_busy;
  int          m_w;
  logic [31:0] m_cyc, m_pps, m_evt, m_dead;
  logic [15:0] m_dt;
  logic [7:0]  m_drop;
  logic [31:0] acc_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
    chk({tag, "_present"}, 32'(acc_log.size() > idx), 32'd1);
    if (acc_log.size() > idx)
      chk(tag, acc_log[idx], exp);
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_busy = 0; m_w = 0; m_cur = '0;
    m_cyc = 0; m_pps = 0; m_evt = 0; m_dead = 0; m_dt = 0; m_drop = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; trig_i = 0; trig_info_i = 0; deadtrig_i = 0; dead_i = 0; pps_i = 0; hdr_tready_i = 0;
    @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    rst_i = 0;
    model_clear();
    chk("rst_tvalid", 32'(hdr_tvalid_o), 32'd0);
    chk("rst_tlast",  32'(hdr_tlast_o),  32'd0);
    chk("rst_tdata",  hdr_tdata_o,       32'd0);
    chk("rst_full",   32'(hdr_full_o),   32'd0);
    chk("rst_count",  32'(hdr_count_o),  32'd0);
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs, advance the model.
  task automatic tick(input bit t, input logic [15:0] info, input bit dtr, input bit dd,
                      input bit p, input bit rdy);
    bit word_acc, last_acc, pop_now, acc;
    pkt_t pk;
    trig_i = t; trig_info_i = info; deadtrig_i = dtr; dead_i = dd; pps_i = p; hdr_tready_i = rdy;
    chk("tvalid", 32'(hdr_tvalid_o), 32'(m_busy));
    chk("count",  32'(hdr_count_o),  32'(m_fifo.size()));
    chk("full",   32'(hdr_full_o),   32'(m_fifo.size() == DEPTH));
    if (m_busy) begin
      chk("tdata", hdr_tdata_o, m_cur[m_w]);
      chk("tlast", 32'(hdr_tlast_o), 32'(m_w == NW - 1));
      if (rdy) acc_log.push_back(hdr_tdata_o);
    end
    word_acc = m_busy && rdy;
    last_acc = word_acc && (m_w == NW - 1);
    pop_now  = (m_fifo.size() > 0) && (!m_busy || last_acc);
    acc      = t && ((m_fifo.size() < DEPTH) || pop_now);
    m_cyc = p ? 32'd0 : m_cyc + 1;
    m_pps = m_pps + 32'(p);
    if (pop_now) begin
      m_cur = m_fifo.pop_front(); m_busy = 1; m_w = 0;
    end else if (last_acc) begin
      m_busy = 0;
    end else if (word_acc) begin
      m_w++;
    end
    if (acc) begin
      pk = '0;
      pk[0] = {8'hEB, m_drop, info};
      pk[1] = m_evt;
      pk[2] = m_pps;
      pk[3] = m_cyc;
      pk[4] = {16'h0000, m_dt};
      pk[5] = m_dead;
      m_fifo.push_back(pk);
      m_evt++;
      m_dt = 16'(dtr); m_drop = 0; m_dead = 32'(dd);
    end else begin
      if (t && m_drop != 8'hFF) m_drop++;
      if (dtr && m_dt != 16'hFFFF) m_dt++;
      if (dd && m_dead != 32'hFFFF_FFFF) m_dead++;
    end
    @(posedge sys_clk_i);
    @(negedge sys_clk_i);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(0, 16'h0, 0, 0, 0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (m_busy || m_fifo.size() > 0); i++) tick(0, 16'h0, 0, 0, 0, 1);
    chk("drain_tvalid", 32'(hdr_tvalid_o), 32'd0);
  endtask

  initial begin
    rst_i = 1; trig_i = 0; trig_info_i = 0; deadtrig_i = 0; dead_i = 0; pps_i = 0; hdr_tready_i = 0;
    @(negedge sys_clk_i);

    // Single trigger: pps at cycle 10, trigger at cycle 110
    do_reset();
    acc_log.delete();
    idle(10, 1);
    tick(0, 16'h0, 0, 0, 1, 1);
    idle(99, 1);
    tick(1, 16'h0005, 0, 0, 0, 1);
    chk("lat_n1", 32'(hdr_tvalid_o), 32'd0);
    tick(0, 16'h0, 0, 0, 0, 1);
    chk("lat_n2", 32'(hdr_tvalid_o), 32'd1);
    drain();
    chk_log("single_w0", 0, 32'hEB00_0005);
    chk_log("single_w1", 1, 32'd0);
    chk_log("single_w2", 2, 32'd1);
    chk_log("single_w3", 3, 32'd100);
    chk_log("single_w4", 4, 32'd0);
    chk("single_len", 32'(acc_log.size()), 32'(NW));

    // Backpressure: three back-to-back triggers, ready toggling
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 3; i++) tick(1, 16'(16'h0100 + i), 0, 0, 0, i[0]);
    for (int i = 0; i < 40; i++) tick(0, 16'h0, 0, 0, 0, i[0]);
    drain();
    chk_log("bp_evt0", 1, 32'd0);
    chk_log("bp_evt1", NW + 1, 32'd1);
    chk_log("bp_evt2", 2 * NW + 1, 32'd2);
    chk("bp_len", 32'(acc_log.size()), 32'(3 * NW));

    // Overflow: one header parked in the serialiser, then DEPTH+3 triggers with ready low
    do_reset();
    tick(1, 16'h00AA, 0, 0, 0, 0);
    idle(2, 0);
    for (int i = 0; i < DEPTH + 3; i++) tick(1, 16'(i), 0, 0, 0, 0);
    chk("ovf_full", 32'(hdr_full_o), 32'd1);
    chk("ovf_count", 32'(hdr_count_o), 32'(DEPTH));
    drain();
    acc_log.delete();
    tick(1, 16'h0777, 0, 0, 0, 1);
    drain();
    chk_log("ovf_drop", 0, 32'hEB03_0777);
    chk_log("ovf_evt", 1, 32'(DEPTH + 1));

    // Coincidence: pps with trigger, deadtrig with trigger
    do_reset();
    acc_log.delete();
    idle(5, 1);
    tick(0, 16'h0, 0, 0, 1, 1);
    idle(20, 1);
    tick(1, 16'h0011, 0, 0, 1, 1);
    idle(10, 1);
    tick(1, 16'h0022, 1, 0, 0, 1);
    idle(10, 1);
    tick(1, 16'h0033, 0, 0, 0, 1);
    drain();
    chk_log("coin_cyc", 3, 32'd0);
    chk_log("coin_pps", 2, 32'd2);
    chk_log("coin_dt_now", NW + 4, 32'd0);
    chk_log("coin_dt_next", 2 * NW + 4, 32'd1);

    // Saturation of the dead-trigger counter
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 70000; i++) tick(0, 16'h0, 1, 0, 0, 1);
    tick(1, 16'h0044, 0, 0, 0, 1);
    idle(3, 1);
    tick(1, 16'h0055, 0, 0, 0, 1);
    drain();
    chk_log("sat_dt", 4, 32'h0000_FFFF);
    chk_log("sat_dt_next", NW + 4, 32'd0);

    // Reset after word 2 accepted
    do_reset();
    tick(1, 16'h0066, 0, 0, 0, 1);
    for (int i = 0; i < 20 && !(m_busy && m_w == 3); i++) tick(0, 16'h0, 0, 0, 0, 1);
    chk("mid_valid", 32'(hdr_tvalid_o), 32'd1);
    do_reset();
    acc_log.delete();
    tick(1, 16'h0088, 0, 0, 0, 1);
    drain();
    chk_log("mid_evt", 1, 32'd0);
    chk("mid_len", 32'(acc_log.size()), 32'(NW));

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 800; i++)
      tick($urandom_range(3) == 0, 16'($urandom), $urandom_range(4) == 0, $urandom_range(1) == 1,
           $urandom_range(60) == 0, $urandom_range(2) != 0);
    for (int i = 0; i < 200; i++)
      tick($urandom_range(1) == 0, 16'($urandom), $urandom_range(1) == 0, 1,
           $urandom_range(30) == 0, $urandom_range(5) == 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
